// File: rtl/debug_cmd_sysclk_bridge.sv
// System-clock half of the debug slave: synchronises TCK-domain update strobes, queues captured
// commands in a show-ahead FIFO and drains them into one-hot take pulses plus a registered jdo.
module debug_cmd_sysclk_bridge #(
  parameter int unsigned IR_W         = 2,
  parameter int unsigned SR_W         = 38,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter bit          FLUSH_ON_UIR = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    udr_async,
  input  logic                    uir_async,
  input  logic [IR_W-1:0]         ir_in,
  input  logic [SR_W-1:0]         sr,
  input  logic                    cmd_ready,
  input  logic                    ovf_clr,
  output logic                    cmd_valid,
  output logic [IR_W-1:0]         cmd_ir,
  output logic [SR_W-1:0]         cmd_data,
  output logic [SR_W-1:0]         jdo,
  output logic [(2**IR_W)-1:0]    take_action,
  output logic [(2**IR_W)-1:0]    take_no_action,
  output logic                    ir_update,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic                    overflow,
  output logic [7:0]              drop_count
);

  localparam int unsigned NCH = 2 ** IR_W;
  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned LW  = PW + 1;
  localparam int unsigned AW  = $clog2(SYNC_STAGES + 2);
  localparam int unsigned EW  = IR_W + SR_W;
  localparam logic [LW-1:0] DepthL = LW'(DEPTH);
  localparam logic [AW-1:0] ArmMax = AW'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] udr_sync_q, uir_sync_q;
  logic                   udr_prev_q, uir_prev_q;
  logic [AW-1:0]          arm_cnt_q;
  logic                   armed, udr_edge, uir_edge;

  logic [EW-1:0]          mem_q [DEPTH];
  logic [PW-1:0]          wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0]          level_q, level_d;
  logic [SR_W-1:0]        jdo_q, jdo_d;
  logic [NCH-1:0]         take_action_q, take_action_d, take_no_action_q, take_no_action_d;
  logic                   ir_update_q;
  logic                   overflow_q, overflow_d;
  logic [7:0]             drop_count_q, drop_count_d, cnt_base;

  logic [EW-1:0]          head;
  logic [IR_W-1:0]        head_ir;
  logic [SR_W-1:0]        head_data;
  logic                   flush, pop, full, push, drop;

  // Edges are masked until the synchroniser has flushed out whatever was sampled at release.
  assign armed    = (arm_cnt_q == ArmMax);
  assign udr_edge = armed & udr_sync_q[SYNC_STAGES-1] & ~udr_prev_q;
  assign uir_edge = armed & uir_sync_q[SYNC_STAGES-1] & ~uir_prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      udr_sync_q <= '0;
      uir_sync_q <= '0;
      udr_prev_q <= 1'b0;
      uir_prev_q <= 1'b0;
      arm_cnt_q  <= '0;
    end else begin
      udr_sync_q <= {udr_sync_q[SYNC_STAGES-2:0], udr_async};
      uir_sync_q <= {uir_sync_q[SYNC_STAGES-2:0], uir_async};
      udr_prev_q <= udr_sync_q[SYNC_STAGES-1];
      uir_prev_q <= uir_sync_q[SYNC_STAGES-1];
      if (!armed) arm_cnt_q <= arm_cnt_q + 1'b1;
    end
  end

  assign head      = mem_q[rptr_q];
  assign head_ir   = head[EW-1:SR_W];
  assign head_data = head[SR_W-1:0];

  always_comb begin
    flush = FLUSH_ON_UIR && uir_edge;
    pop   = cmd_valid && cmd_ready && !flush;
    full  = (level_q == DepthL);
    push  = udr_edge && (!full || pop || flush);
    drop  = udr_edge && !push;

    wptr_d = push ? wptr_q + 1'b1 : wptr_q;
    if (flush) begin
      rptr_d  = wptr_q;
      level_d = push ? LW'(1) : '0;
    end else begin
      rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
      level_d = level_q;
      if (push && !pop) level_d = level_q + LW'(1);
      if (pop && !push) level_d = level_q - LW'(1);
    end

    take_action_d    = '0;
    take_no_action_d = '0;
    jdo_d            = jdo_q;
    if (pop) begin
      jdo_d = head_data;
      if (head_data[SR_W-1]) take_action_d[head_ir] = 1'b1;
      else                   take_no_action_d[head_ir] = 1'b1;
    end

    // A drop in the same cycle as a clear counts from zero.
    cnt_base = ovf_clr ? 8'd0 : drop_count_q;
    if (drop) begin
      overflow_d   = 1'b1;
      drop_count_d = (cnt_base == 8'hFF) ? 8'hFF : cnt_base + 8'd1;
    end else begin
      overflow_d   = overflow_q & ~ovf_clr;
      drop_count_d = cnt_base;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {ir_in, sr};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q           <= '0;
      rptr_q           <= '0;
      level_q          <= '0;
      jdo_q            <= '0;
      take_action_q    <= '0;
      take_no_action_q <= '0;
      ir_update_q      <= 1'b0;
      overflow_q       <= 1'b0;
      drop_count_q     <= '0;
    end else begin
      wptr_q           <= wptr_d;
      rptr_q           <= rptr_d;
      level_q          <= level_d;
      jdo_q            <= jdo_d;
      take_action_q    <= take_action_d;
      take_no_action_q <= take_no_action_d;
      ir_update_q      <= uir_edge;
      overflow_q       <= overflow_d;
      drop_count_q     <= drop_count_d;
    end
  end

  assign cmd_valid      = (level_q != '0);
  assign cmd_ir         = cmd_valid ? head_ir : '0;
  assign cmd_data       = cmd_valid ? head_data : '0;
  assign jdo            = jdo_q;
  assign take_action    = take_action_q;
  assign take_no_action = take_no_action_q;
  assign ir_update      = ir_update_q;
  assign fifo_level     = level_q;
  assign overflow       = overflow_q;
  assign drop_count     = drop_count_q;

endmodule
